// File: rtl/vend_scheduler.sv
// Two-slot ticket vending scheduler: per-slot credit and refunds, with round-robin arbitration
// of a shared dispenser and a sticky fault on dispenser acknowledge timeout.
module vend_scheduler #(
    parameter int unsigned PRICE       = 3,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] coin_a,
    input  logic [1:0] coin_b,
    input  logic       cancel_a,
    input  logic       cancel_b,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic       disp_slot,
    output logic       ticket_a,
    output logic       ticket_b,
    output logic [2:0] credit_a,
    output logic [2:0] credit_b,
    output logic       refund_a,
    output logic       refund_b,
    output logic [3:0] refund_amt_a,
    output logic [3:0] refund_amt_b,
    output logic       fault
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StGrant = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;
    localparam logic [1:0] StFault = 2'd3;

    localparam logic [3:0] PriceW  = 4'(PRICE);
    localparam logic [7:0] TmoLast = 8'(ACK_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic       slot_q, slot_d;
    logic       rr_q, rr_d;
    logic [7:0] tmo_q, tmo_d;
    logic [2:0] credit_a_q, credit_a_d;
    logic [2:0] credit_b_q, credit_b_d;
    logic       refund_a_q, refund_a_d;
    logic       refund_b_q, refund_b_d;
    logic [3:0] amt_a_q, amt_a_d;
    logic [3:0] amt_b_q, amt_b_d;

    logic       granted_a, granted_b;
    logic       pend_a, pend_b;
    logic [3:0] sum_a, sum_b;

    function automatic logic [3:0] coin_val(input logic [1:0] c);
        return (c == 2'b11) ? 4'd0 : {2'b00, c};
    endfunction

    function automatic logic [2:0] sat7(input logic [3:0] v);
        return (v > 4'd7) ? 3'd7 : v[2:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        rr_d       = rr_q;
        tmo_d      = tmo_q;
        refund_a_d = 1'b0;
        refund_b_d = 1'b0;
        amt_a_d    = 4'd0;
        amt_b_d    = 4'd0;

        granted_a = ((state_q == StGrant) || (state_q == StDone)) && !slot_q;
        granted_b = ((state_q == StGrant) || (state_q == StDone)) && slot_q;

        sum_a = {1'b0, credit_a_q} + coin_val(coin_a);
        sum_b = {1'b0, credit_b_q} + coin_val(coin_b);

        // A slot being refunded this cycle is not offered for a grant.
        pend_a = ({1'b0, credit_a_q} >= PriceW) && !granted_a && !cancel_a;
        pend_b = ({1'b0, credit_b_q} >= PriceW) && !granted_b && !cancel_b;

        if (state_q == StDone && !slot_q) begin
            credit_a_d = sat7(sum_a - PriceW);
        end else if (cancel_a && !granted_a) begin
            credit_a_d = 3'd0;
            refund_a_d = 1'b1;
            amt_a_d    = sum_a;
        end else begin
            credit_a_d = sat7(sum_a);
        end

        if (state_q == StDone && slot_q) begin
            credit_b_d = sat7(sum_b - PriceW);
        end else if (cancel_b && !granted_b) begin
            credit_b_d = 3'd0;
            refund_b_d = 1'b1;
            amt_b_d    = sum_b;
        end else begin
            credit_b_d = sat7(sum_b);
        end

        case (state_q)
            StIdle: begin
                if (pend_a || pend_b) begin
                    state_d = StGrant;
                    tmo_d   = 8'd0;
                    slot_d  = (pend_a && pend_b) ? rr_q : pend_b;
                    rr_d    = ~slot_d;
                end
            end
            StGrant: begin
                if (disp_ack) begin
                    state_d = StDone;
                end else if (tmo_q == TmoLast) begin
                    state_d = StFault;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StFault;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            slot_q     <= 1'b0;
            rr_q       <= 1'b0;
            tmo_q      <= 8'd0;
            credit_a_q <= 3'd0;
            credit_b_q <= 3'd0;
            refund_a_q <= 1'b0;
            refund_b_q <= 1'b0;
            amt_a_q    <= 4'd0;
            amt_b_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            rr_q       <= rr_d;
            tmo_q      <= tmo_d;
            credit_a_q <= credit_a_d;
            credit_b_q <= credit_b_d;
            refund_a_q <= refund_a_d;
            refund_b_q <= refund_b_d;
            amt_a_q    <= amt_a_d;
            amt_b_q    <= amt_b_d;
        end
    end

    assign disp_req     = (state_q == StGrant);
    assign disp_slot    = (state_q == StGrant) && slot_q;
    assign ticket_a     = (state_q == StDone) && !slot_q;
    assign ticket_b     = (state_q == StDone) && slot_q;
    assign fault        = (state_q == StFault);
    assign credit_a     = credit_a_q;
    assign credit_b     = credit_b_q;
    assign refund_a     = refund_a_q;
    assign refund_b     = refund_b_q;
    assign refund_amt_a = amt_a_q;
    assign refund_amt_b = amt_b_q;

endmodule

// File: tb/tb_vend_scheduler.sv
// Directed bench for vend_scheduler with PRICE=3, ACK_TIMEOUT=15.
module tb_vend_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] coin_a = 2'b00;
    logic [1:0] coin_b = 2'b00;
    logic       cancel_a = 1'b0;
    logic       cancel_b = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req, disp_slot, ticket_a, ticket_b;
    logic [2:0] credit_a, credit_b;
    logic       refund_a, refund_b;
    logic [3:0] refund_amt_a, refund_amt_b;
    logic       fault;

    int total = 0;
    int bad   = 0;

    vend_scheduler #(
        .PRICE       (3),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_a       (coin_a),
        .coin_b       (coin_b),
        .cancel_a     (cancel_a),
        .cancel_b     (cancel_b),
        .disp_ack     (disp_ack),
        .disp_req     (disp_req),
        .disp_slot    (disp_slot),
        .ticket_a     (ticket_a),
        .ticket_b     (ticket_b),
        .credit_a     (credit_a),
        .credit_b     (credit_b),
        .refund_a     (refund_a),
        .refund_b     (refund_b),
        .refund_amt_a (refund_amt_a),
        .refund_amt_b (refund_amt_b),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample point is 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] ca, input logic [1:0] cb);
        coin_a = ca;
        coin_b = cb;
        cyc();
        coin_a = 2'b00;
        coin_b = 2'b00;
    endtask

    task automatic ack_pulse();
        disp_ack = 1'b1;
        cyc();
        disp_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({disp_req, disp_slot, ticket_a, ticket_b, refund_a, refund_b, fault} !== 7'd0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {disp_req, disp_slot, ticket_a, ticket_b, refund_a, refund_b, fault});
        end
        total++;
        if ({credit_a, credit_b, refund_amt_a, refund_amt_b} !== 14'd0) begin
            bad++;
            $display("FAIL reset_values: got ca=%0d cb=%0d ra=%0d rb=%0d want 0",
                     credit_a, credit_b, refund_amt_a, refund_amt_b);
        end
    endtask

    task automatic test_purchase();
        do_reset();
        load(2'b01, 2'b00);
        total++;
        if (credit_a !== 3'd1) begin bad++; $display("FAIL buy_credit1: got %0d want 1", credit_a); end
        load(2'b10, 2'b00);
        total++;
        if (credit_a !== 3'd3 || disp_req !== 1'b0) begin
            bad++; $display("FAIL buy_credit3: got %0d req=%b want 3 req=0", credit_a, disp_req);
        end
        cyc();
        total++;
        if (disp_req !== 1'b1 || disp_slot !== 1'b0) begin
            bad++; $display("FAIL buy_grant: got req=%b slot=%b want 1 0", disp_req, disp_slot);
        end
        cyc();
        total++;
        if (disp_req !== 1'b1 || disp_slot !== 1'b0) begin
            bad++; $display("FAIL buy_hold: got req=%b slot=%b want 1 0", disp_req, disp_slot);
        end
        ack_pulse();
        total++;
        if (ticket_a !== 1'b1 || ticket_b !== 1'b0 || disp_req !== 1'b0) begin
            bad++; $display("FAIL buy_done: got ta=%b tb=%b req=%b want 1 0 0",
                            ticket_a, ticket_b, disp_req);
        end
        cyc();
        total++;
        if (credit_a !== 3'd0 || ticket_a !== 1'b0) begin
            bad++; $display("FAIL buy_after: got credit=%0d ta=%b want 0 0", credit_a, ticket_a);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        load(2'b10, 2'b10);
        load(2'b01, 2'b01);
        cyc();
        total++;
        if (disp_req !== 1'b1 || disp_slot !== 1'b0) begin
            bad++; $display("FAIL rr_first_a: got req=%b slot=%b want 1 0", disp_req, disp_slot);
        end
        ack_pulse();
        cyc();
        total++;
        if (disp_req !== 1'b0 || credit_a !== 3'd0 || credit_b !== 3'd3) begin
            bad++; $display("FAIL rr_gap: got req=%b ca=%0d cb=%0d want 0 0 3",
                            disp_req, credit_a, credit_b);
        end
        cyc();
        total++;
        if (disp_req !== 1'b1 || disp_slot !== 1'b1) begin
            bad++; $display("FAIL rr_then_b: got req=%b slot=%b want 1 1", disp_req, disp_slot);
        end
        ack_pulse();
        total++;
        if (ticket_b !== 1'b1 || ticket_a !== 1'b0) begin
            bad++; $display("FAIL rr_ticket_b: got ta=%b tb=%b want 0 1", ticket_a, ticket_b);
        end
        cyc();
        load(2'b11, 2'b00);
        total++;
        if (credit_a !== 3'd0) begin bad++; $display("FAIL coin11: got %0d want 0", credit_a); end
        load(2'b10, 2'b00);
        load(2'b01, 2'b00);
        cyc();
        ack_pulse();
        cyc();
        // Last grant went to A, so the next tie must go to B.
        load(2'b10, 2'b10);
        load(2'b01, 2'b01);
        cyc();
        total++;
        if (disp_req !== 1'b1 || disp_slot !== 1'b1) begin
            bad++; $display("FAIL rr_alt_b: got req=%b slot=%b want 1 1", disp_req, disp_slot);
        end
    endtask

    task automatic test_cancel();
        do_reset();
        load(2'b00, 2'b10);
        cancel_b = 1'b1;
        load(2'b00, 2'b10);
        cancel_b = 1'b0;
        total++;
        if (refund_b !== 1'b1 || refund_amt_b !== 4'd4 || credit_b !== 3'd0 || refund_a !== 1'b0) begin
            bad++; $display("FAIL cancel_refund: got rf=%b amt=%0d cb=%0d ra=%b want 1 4 0 0",
                            refund_b, refund_amt_b, credit_b, refund_a);
        end
        cyc();
        total++;
        if (refund_b !== 1'b0 || refund_amt_b !== 4'd0 || disp_req !== 1'b0) begin
            bad++; $display("FAIL cancel_after: got rf=%b amt=%0d req=%b want 0 0 0",
                            refund_b, refund_amt_b, disp_req);
        end
    endtask

    task automatic test_fault();
        do_reset();
        load(2'b10, 2'b00);
        load(2'b01, 2'b00);
        cyc();
        for (int i = 0; i < 14; i++) cyc();
        total++;
        if (disp_req !== 1'b1 || fault !== 1'b0) begin
            bad++; $display("FAIL tmo_last_grant: got req=%b fault=%b want 1 0", disp_req, fault);
        end
        cyc();
        total++;
        if (disp_req !== 1'b0 || fault !== 1'b1) begin
            bad++; $display("FAIL tmo_fault: got req=%b fault=%b want 0 1", disp_req, fault);
        end
        cancel_a = 1'b1;
        load(2'b00, 2'b01);
        cancel_a = 1'b0;
        total++;
        if (refund_a !== 1'b1 || refund_amt_a !== 4'd3 || credit_a !== 3'd0 || credit_b !== 3'd1) begin
            bad++; $display("FAIL fault_refund: got rf=%b amt=%0d ca=%0d cb=%0d want 1 3 0 1",
                            refund_a, refund_amt_a, credit_a, credit_b);
        end
        load(2'b00, 2'b10);
        cyc();
        cyc();
        total++;
        if (disp_req !== 1'b0 || fault !== 1'b1 || credit_b !== 3'd3) begin
            bad++; $display("FAIL fault_sticky: got req=%b fault=%b cb=%0d want 0 1 3",
                            disp_req, fault, credit_b);
        end
        rst = 1'b0;
        #1;
        total++;
        if (fault !== 1'b0 || credit_b !== 3'd0) begin
            bad++; $display("FAIL fault_reset: got fault=%b cb=%0d want 0 0", fault, credit_b);
        end
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_saturate();
        do_reset();
        load(2'b00, 2'b10);
        load(2'b00, 2'b01);
        cyc();
        for (int i = 0; i < 7; i++) load(2'b01, 2'b00);
        total++;
        if (credit_a !== 3'd7 || disp_slot !== 1'b1 || credit_b !== 3'd3) begin
            bad++; $display("FAIL sat_seven: got ca=%0d slot=%b cb=%0d want 7 1 3",
                            credit_a, disp_slot, credit_b);
        end
        cancel_b = 1'b1;
        load(2'b01, 2'b00);
        cancel_b = 1'b0;
        total++;
        if (credit_a !== 3'd7 || refund_b !== 1'b0 || credit_b !== 3'd3) begin
            bad++; $display("FAIL sat_eighth: got ca=%0d rfb=%b cb=%0d want 7 0 3",
                            credit_a, refund_b, credit_b);
        end
        ack_pulse();
        total++;
        if (ticket_b !== 1'b1) begin bad++; $display("FAIL sat_ticket_b: got %b want 1", ticket_b); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        load(2'b10, 2'b00);
        load(2'b01, 2'b00);
        cyc();
        disp_ack = 1'b1;
        rst = 1'b0;
        #1;
        total++;
        if (disp_req !== 1'b0 || credit_a !== 3'd0 || fault !== 1'b0) begin
            bad++; $display("FAIL rst_async: got req=%b ca=%0d fault=%b want 0 0 0",
                            disp_req, credit_a, fault);
        end
        cyc();
        rst = 1'b1;
        disp_ack = 1'b0;
        cyc();
        total++;
        if (ticket_a !== 1'b0 || refund_a !== 1'b0 || disp_req !== 1'b0) begin
            bad++; $display("FAIL rst_no_ticket: got ta=%b ra=%b req=%b want 0 0 0",
                            ticket_a, refund_a, disp_req);
        end
        load(2'b10, 2'b00);
        load(2'b01, 2'b00);
        cyc();
        ack_pulse();
        total++;
        if (ticket_a !== 1'b1) begin bad++; $display("FAIL rst_resume: got %b want 1", ticket_a); end
    endtask

    initial begin
        test_reset();
        test_purchase();
        test_round_robin();
        test_cancel();
        test_fault();
        test_saturate();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
